// File: rtl/elastic_fifo.sv
// elastic_fifo: depth_p-entry ring-buffer FIFO with valid/ready handshakes on
// both sides. ready_o and valid_o come from registered occupancy only, so there
// is no combinational path from ready_i to ready_o. Supports synchronous flush
// and reports occupancy.
module elastic_fifo #(
    parameter int width_p          = 8,
    parameter int depth_p          = 4,
    parameter bit datapath_reset_p = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(depth_p+1)-1:0] count_o
);

    localparam int ptr_w = $clog2(depth_p);
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth_p);
    localparam logic [ptr_w-1:0] last_c  = ptr_w'(depth_p - 1);

    logic [width_p-1:0] mem [depth_p];
    logic [ptr_w-1:0]   wr_ptr_r;
    logic [ptr_w-1:0]   rd_ptr_r;
    logic [cnt_w-1:0]   count_r;

    logic push;
    logic pop;
    logic clear;
    logic push_en;
    logic [ptr_w-1:0] wr_ptr_next;
    logic [ptr_w-1:0] rd_ptr_next;

    assign ready_o = (count_r != depth_c);
    assign valid_o = (count_r != '0);
    assign data_o  = mem[rd_ptr_r];
    assign count_o = count_r;

    assign push  = valid_i & ready_o;
    assign pop   = valid_o & ready_i;
    assign clear = reset_i | flush_i;
    // A beat offered during reset/flush is dropped, so it must not reach storage.
    assign push_en = push & ~clear;

    // Explicit wrap at depth_p-1 so non-power-of-two depths work.
    assign wr_ptr_next = (wr_ptr_r == last_c) ? '0 : wr_ptr_r + ptr_w'(1);
    assign rd_ptr_next = (rd_ptr_r == last_c) ? '0 : rd_ptr_r + ptr_w'(1);

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_next;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_w'(1);
                2'b01:   count_r <= count_r - cnt_w'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    generate
        if (datapath_reset_p) begin : g_mem_rst
            // Storage write; whole array cleared on reset/flush so data_o reads 0.
            always_ff @(posedge clk_i) begin
                if (clear) begin
                    for (int i = 0; i < depth_p; i++) begin
                        mem[i] <= '0;
                    end
                end else if (push_en) begin
                    mem[wr_ptr_r] <= data_i;
                end
            end
        end else begin : g_mem_norst
            // Storage write; contents are left untouched by reset/flush.
            always_ff @(posedge clk_i) begin
                if (push_en) begin
                    mem[wr_ptr_r] <= data_i;
                end
            end
        end
    endgenerate

endmodule
